// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forwarding select
// encodings and the pipeline-control FSM state type.
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result sitting in MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // value being written back

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    // EXE match wins over MEM match; a load in EXE cannot be forwarded
    // (that case is covered by the load-use bubble instead).
    function automatic logic [1:0] fwd_select(input logic match_exe,
                                              input logic match_mem,
                                              input logic exe_is_load);
        if (match_exe && !exe_is_load)
            return FWD_MEM;
        else if (match_mem)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_dep_check.sv
// Combinational dependency comparator: does one ID-stage source register
// depend on the instruction currently in EXE or in MEM?
module dep_check
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_en,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              match_exe,
    output logic              match_mem
);

    assign match_exe = src_en & exe_wb_en & (src == exe_dest);
    assign match_mem = src_en & mem_wb_en & (src == mem_dest);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline control for the 5-stage core: operand forwarding selects,
// load-use stall, memory-wait freeze, branch flush window and a saturating
// stall-cycle counter.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int FWD_EN     = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              branch_taken,
    output logic              hazard,
    output logic              freeze,
    output logic              flush,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Last value of the flush counter; the branch cycle itself is flush cycle 0.
    localparam logic [1:0] PEN_LAST  = 2'(BR_PENALTY - 1);
    localparam bit         MULTI_CYC = (BR_PENALTY > 1);

    logic       m1_exe, m1_mem, m2_exe, m2_mem;
    logic       haz_raw;
    logic       flush_start;
    state_e     state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;
    logic       pending, pending_nxt;
    logic [1:0] sel1_nxt, sel2_nxt;

    // Saturating increment: hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    dep_check #(.REG_AW(REG_AW)) u_dep1 (
        .src       (id_src1),
        .src_en    (1'b1),
        .exe_dest  (exe_dest),
        .exe_wb_en (exe_wb_en),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .match_exe (m1_exe),
        .match_mem (m1_mem)
    );

    dep_check #(.REG_AW(REG_AW)) u_dep2 (
        .src       (id_src2),
        .src_en    (id_two_src),
        .exe_dest  (exe_dest),
        .exe_wb_en (exe_wb_en),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .match_exe (m2_exe),
        .match_mem (m2_mem)
    );

    // Control outputs: freeze beats flush beats hazard; all quiet in reset.
    always_comb begin
        freeze      = rst & mem_req & ~mem_ready;
        flush_start = rst & ~freeze & (state != FLUSH) & (branch_taken | pending);
        flush       = rst & ~freeze & ((state == FLUSH) | flush_start);
        if (FWD_EN != 0)
            haz_raw = (m1_exe | m2_exe) & exe_mem_r_en;
        else
            haz_raw = m1_exe | m1_mem | m2_exe | m2_mem;
        hazard      = rst & haz_raw & ~freeze & ~flush;
        if (FWD_EN != 0) begin
            sel1_nxt = fwd_select(m1_exe, m1_mem, exe_mem_r_en);
            sel2_nxt = fwd_select(m2_exe, m2_mem, exe_mem_r_en);
        end else begin
            sel1_nxt = FWD_RF;
            sel2_nxt = FWD_RF;
        end
    end

    // Next-state logic: memory wait, deferred branch and flush window length.
    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        // A branch seen while frozen is remembered until the pipeline moves;
        // branches arriving inside an open flush window are dropped.
        pending_nxt = freeze ? (pending | (branch_taken & (state != FLUSH))) : 1'b0;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt = MEM_WAIT;
                end else if (flush_start && MULTI_CYC) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = 2'd1;
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    if (flush_start && MULTI_CYC) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = 2'd1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            FLUSH: begin
                if (!freeze) begin
                    if (fcnt == PEN_LAST) begin
                        state_nxt = RUN;
                        fcnt_nxt  = 2'd0;
                    end else begin
                        fcnt_nxt  = fcnt + 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                fcnt_nxt  = 2'd0;
            end
        endcase
    end

    // FSM state, flush counter and deferred-branch flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            fcnt    <= 2'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            fcnt    <= fcnt_nxt;
            pending <= pending_nxt;
        end
    end

    // ID -> EXE boundary: forwarding selects, held while frozen, cleared for bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel1 <= FWD_RF;
            fwd_sel2 <= FWD_RF;
        end else if (!freeze) begin
            if (hazard || flush) begin
                fwd_sel1 <= FWD_RF;
                fwd_sel2 <= FWD_RF;
            end else begin
                fwd_sel1 <= sel1_nxt;
                fwd_sel2 <= sel2_nxt;
            end
        end
    end

    // Stall performance counter: every hazard or freeze cycle, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (hazard || freeze)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl. Three instances share the stimulus:
// forwarding on / 1-cycle branch penalty, legacy stall-only mode, and a
// 2-cycle branch penalty with a 3-bit stall counter for saturation.
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       mem_req, mem_ready, branch_taken;

    logic        hz0, fz0, fl0, hz1, fz1, fl1, hz2, fz2, fl2;
    logic [1:0]  s10, s20, s11, s21, s12, s22;
    logic [15:0] c0, c1;
    logic [2:0]  c2;

    int sel_dut;
    int n_vec;
    int n_err;

    typedef struct {
        string       tag;
        logic        haz;
        logic        frz;
        logic        fl;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    hazard_forward_ctrl #(.REG_AW(4), .FWD_EN(1), .BR_PENALTY(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .hazard(hz0), .freeze(fz0), .flush(fl0),
        .fwd_sel1(s10), .fwd_sel2(s20), .stall_cnt(c0));

    hazard_forward_ctrl #(.REG_AW(4), .FWD_EN(0), .BR_PENALTY(1), .CNT_W(16)) u_leg (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .hazard(hz1), .freeze(fz1), .flush(fl1),
        .fwd_sel1(s11), .fwd_sel2(s21), .stall_cnt(c1));

    hazard_forward_ctrl #(.REG_AW(4), .FWD_EN(1), .BR_PENALTY(2), .CNT_W(3)) u_br (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .hazard(hz2), .freeze(fz2), .flush(fl2),
        .fwd_sel1(s12), .fwd_sel2(s22), .stall_cnt(c2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic obs_comb(output logic h, output logic f, output logic fl);
        case (sel_dut)
            0:       begin h = hz0; f = fz0; fl = fl0; end
            1:       begin h = hz1; f = fz1; fl = fl1; end
            default: begin h = hz2; f = fz2; fl = fl2; end
        endcase
    endtask

    task automatic obs_reg(output logic [1:0] a, output logic [1:0] b, output logic [15:0] c);
        case (sel_dut)
            0:       begin a = s10; b = s20; c = c0; end
            1:       begin a = s11; b = s21; c = c1; end
            default: begin a = s12; b = s22; c = {13'd0, c2}; end
        endcase
    endtask

    // One cycle: drive inputs at the falling edge, check combinational outputs
    // just after, then check the registered outputs just after the rising edge.
    task automatic step(input string tag,
                        input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic [3:0] ed, input logic ew, input logic el,
                        input logic [3:0] md, input logic mw,
                        input logic mq, input logic mr, input logic br,
                        input logic eh, input logic ef, input logic efl,
                        input logic [1:0] es1, input logic [1:0] es2, input int ec);
        exp_t e;
        logic h, f, fl;
        logic [1:0] a, b;
        logic [15:0] c;
        @(negedge clk);
        id_src1 = s1; id_src2 = s2; id_two_src = two;
        exe_dest = ed; exe_wb_en = ew; exe_mem_r_en = el;
        mem_dest = md; mem_wb_en = mw;
        mem_req = mq; mem_ready = mr; branch_taken = br;
        sb.push_back('{tag, eh, ef, efl, es1, es2, 16'(ec)});
        #1;
        e = sb.pop_front();
        obs_comb(h, f, fl);
        chk({e.tag, ".hazard"}, {15'd0, h}, {15'd0, e.haz});
        chk({e.tag, ".freeze"}, {15'd0, f}, {15'd0, e.frz});
        chk({e.tag, ".flush"},  {15'd0, fl}, {15'd0, e.fl});
        @(posedge clk);
        #1;
        obs_reg(a, b, c);
        chk({e.tag, ".fwd_sel1"}, {14'd0, a}, {14'd0, e.s1});
        chk({e.tag, ".fwd_sel2"}, {14'd0, b}, {14'd0, e.s2});
        chk({e.tag, ".stall_cnt"}, c, e.cnt);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        step(tag, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sel_dut = 0;
        rst = 1'b0;
        id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;

        //            tag          s1 s2 two  ed ew el  md mw  mq mr br   haz frz fl  sel1   sel2   cnt
        // In reset every control output stays low whatever the inputs say.
        step("rst_quiet",  4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        rst = 1'b1;

        // Forwarding instance, 1-cycle branch penalty.
        step("add_sub",    4'd1, 4'd5, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 0);
        step("src2_wb",    4'd7, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 0);
        step("exe_prio",   4'd6, 4'd6, 1'b0, 4'd6, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 0);
        step("ldr_use",    4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        step("ldr_bubble", 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1);
        step("frz1",       4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2);
        step("frz2",       4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 3);
        step("frz3",       4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 4);
        step("mem_done",   4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4);
        step("br_flush",   4'd2, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 4);
        step("post_br",    4'd2, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 5);
        step("str_use",    4'd0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 6);
        step("one_src",    4'd0, 4'd9, 1'b0, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 6);

        // Legacy stall-only instance.
        sel_dut = 1;
        do_reset("leg_rst");
        step("leg_exe",    4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1);
        step("leg_mem",    4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2);
        step("leg_clear",  4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2);
        step("leg_src2",   4'd0, 4'd8, 1'b1, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3);

        // Two-cycle branch penalty instance, 3-bit counter.
        sel_dut = 2;
        do_reset("br_rst");
        step("br_in_frz",  4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1);
        step("frz_hold",   4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2);
        step("pend_fl1",   4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2);
        step("pend_fl2",   4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2);
        step("no_restart", 4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2);
        step("br2_a",      4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2);
        step("fl_frz",     4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3);
        step("br2_b",      4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3);
        step("br2_end",    4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3);
        step("br3_a",      4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3);
        // Reset lands in the middle of the flush window.
        rst = 1'b0;
        step("rst_midfl",  4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        rst = 1'b1;
        step("after_rst",  4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        // Long freeze drives the 3-bit counter into saturation.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("sat%0d", i),
                 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, (i + 1 > 7) ? 7 : i + 1);
        end
        step("sat_haz",    4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
